counter_load_stim_chk: RTL and testbench

- Hardware-side partner to the loadable counter. It drives the counter's load and data_in pins and checks its data_out against an internal reference model.
- Used for in-system self-test and as an active agent beside the counter in the counter_inf environment.
- A host issues commands of the form "load value V, then check N consecutive samples". The block reports pass/fail statistics and captures the first mismatch.

---
 rtl/counter_load_stim_chk.sv | 138 +++++++++++++
 tb/tb_counter_load_stim_chk.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_load_stim_chk.sv
// rtl/counter_load_stim_chk.sv - load/check stimulus agent for the loadable counter
// Optional CHK_ERR_INDEX_EN adds err_idx, the run index of the first captured mismatch.
module counter_load_stim_chk #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_value,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic             clr_stats,
  output logic             load,
  output logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             err_valid,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got
`ifdef CHK_ERR_INDEX_EN
  ,
  output logic [LEN_W-1:0] err_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q;
  logic [LEN_W-1:0] remaining_q;
  logic [WIDTH-1:0] data_in_q;
  logic             compare_en;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    cmd_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = rst;
        if (cmd_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = (remaining_q != '0) ? S_CHECK : S_DONE;
      end
      S_CHECK: begin
        if (abort || remaining_q == LEN_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // An aborted CHECK cycle is dropped entirely rather than compared.
  assign compare_en = (state_q == S_CHECK) && !abort;
  assign mismatch   = compare_en && (data_out != exp_q);
  assign data_in    = data_in_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q       <= '0;
      remaining_q <= '0;
      data_in_q   <= '0;
    end else if (state_q == S_IDLE && cmd_valid) begin
      exp_q       <= cmd_value;
      remaining_q <= cmd_len;
      data_in_q   <= cmd_value;
    end else if (state_q == S_CHECK) begin
      exp_q       <= exp_q + WIDTH'(1);
      remaining_q <= remaining_q - LEN_W'(1);
    end
  end

`ifdef CHK_ERR_INDEX_EN
  logic [LEN_W-1:0] idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                idx_q <= '0;
    else if (state_q == S_LOAD) idx_q <= '0;
    else if (compare_en)     idx_q <= idx_q + LEN_W'(1);
  end
`endif

  // A clear coinciding with a mismatch keeps that mismatch as the new first error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch_cnt <= '0;
      err_valid    <= 1'b0;
      err_exp      <= '0;
      err_got      <= '0;
`ifdef CHK_ERR_INDEX_EN
      err_idx      <= '0;
`endif
    end else if (clr_stats) begin
      mismatch_cnt <= mismatch ? CNT_W'(1) : '0;
      err_valid    <= mismatch;
      err_exp      <= mismatch ? exp_q : '0;
      err_got      <= mismatch ? data_out : '0;
`ifdef CHK_ERR_INDEX_EN
      err_idx      <= mismatch ? idx_q : '0;
`endif
    end else if (mismatch) begin
      if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
      if (!err_valid) begin
        err_valid <= 1'b1;
        err_exp   <= exp_q;
        err_got   <= data_out;
`ifdef CHK_ERR_INDEX_EN
        err_idx   <= idx_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_counter_load_stim_chk.sv
// tb/tb_counter_load_stim_chk.sv - directed and randomized bench with counter model and stats reference
module tb_counter_load_stim_chk;
  localparam int WIDTH   = 4;
  localparam int LEN_W   = 16;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_value = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             abort = 1'b0;
  logic             clr_stats = 1'b0;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             err_valid;
  logic [WIDTH-1:0] err_exp;
  logic [WIDTH-1:0] err_got;
`ifdef CHK_ERR_INDEX_EN
  logic [LEN_W-1:0] err_idx;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  counter_load_stim_chk #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_value(cmd_value), .cmd_len(cmd_len), .abort(abort), .clr_stats(clr_stats),
    .load(load), .data_in(data_in), .data_out(data_out), .busy(busy), .done(done),
    .mismatch_cnt(mismatch_cnt), .err_valid(err_valid), .err_exp(err_exp), .err_got(err_got)
`ifdef CHK_ERR_INDEX_EN
    , .err_idx(err_idx)
`endif
  );

  // Counter under check: mode 0 ideal (with optional per-sample xor noise), mode 1 stuck at loaded value.
  logic [WIDTH-1:0] ctr = '0;
  logic [WIDTH-1:0] hold = '0;
  int               sidx = 0;
  int               mode = 0;
  logic [WIDTH-1:0] noise [64];

  always @(posedge clk) begin
    if (load) begin
      ctr  <= data_in;
      hold <= data_in;
      sidx <= 0;
    end else begin
      ctr <= ctr + 1'b1;
      if (sidx < 1000) sidx <= sidx + 1;
    end
  end

  assign data_out = (mode == 1) ? hold : (ctr ^ noise[sidx % 64]);

  int         m_cnt = 0;
  bit         m_ev = 0;
  logic [3:0] m_ee = '0;
  logic [3:0] m_eg = '0;
  int         m_idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_noise(input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0:       noise[i] = '0;
        1:       noise[i] = 4'($urandom_range(1, 15));
        default: noise[i] = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      endcase
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_ev = 0; m_ee = '0; m_eg = '0; m_idx = 0;
  endtask

  task automatic check_stats(input string tag);
    check({tag, ".cnt"}, 32'(mismatch_cnt), 32'(m_cnt));
    check({tag, ".ev"}, 32'(err_valid), 32'(m_ev));
    check({tag, ".exp"}, 32'(err_exp), 32'(m_ee));
    check({tag, ".got"}, 32'(err_got), 32'(m_eg));
`ifdef CHK_ERR_INDEX_EN
    check({tag, ".idx"}, 32'(err_idx), 32'(m_idx));
`endif
  endtask

  task automatic run_cmd(input logic [3:0] v, input int len, input int abort_at,
                         input int clr_at, input bit hold_valid, input string tag);
    int n, exp_done, cyc, done_cnt, done_cyc, load_bad;
    logic [3:0] e, o;
    check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_value = v; cmd_len = LEN_W'(len);
    @(posedge clk); #1;
    if (!hold_valid) cmd_valid = 1'b0;
    check({tag, ".load"}, 32'(load), 32'd1);
    check({tag, ".data_in"}, 32'(data_in), 32'(v));
    check({tag, ".busy"}, 32'(busy), 32'd1);
    if (abort_at > 0 && abort_at <= len) begin
      n = abort_at - 1; exp_done = abort_at + 1;
    end else begin
      n = len; exp_done = len + 1;
    end
    cyc = 0; done_cnt = 0; done_cyc = -1; load_bad = 0;
    for (int k = 0; k < exp_done + 2; k++) begin
      abort     = (abort_at > 0 && cyc == abort_at);
      clr_stats = (clr_at > 0 && cyc == clr_at);
      @(posedge clk); #1;
      cyc++;
      abort = 1'b0; clr_stats = 1'b0;
      if (load) load_bad++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (clr_at > 0 && i == clr_at - 1) model_clear();
      e = v + 4'(i);
      o = (mode == 1) ? v : (e ^ noise[i]);
      if (o != e) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_ev) begin
          m_ev = 1; m_ee = e; m_eg = o; m_idx = i;
        end
      end
    end
    check({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, ".done_cyc"}, 32'(done_cyc), 32'(exp_done));
    check({tag, ".load_low"}, 32'(load_bad), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
    check_stats(tag);
  endtask

  initial begin
    int v, len, ab, cl, n;
    set_noise(0);
    #12;
    check("rst.load", 32'(load), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.ready", 32'(cmd_ready), 32'd0);
    check("rst.data_in", 32'(data_in), 32'd0);
    check_stats("rst");
    @(negedge clk); rst = 1'b1; #1;
    check("rel.ready", 32'(cmd_ready), 32'd1);

    mode = 0; set_noise(0);
    run_cmd(4'hE, 4, 0, 0, 0, "t1");
    mode = 1;
    run_cmd(4'h3, 3, 0, 0, 0, "t2");
    mode = 0; set_noise(0);
    run_cmd(4'h7, 0, 0, 0, 0, "t3");
    set_noise(1);
    run_cmd(4'h9, 8, 3, 0, 0, "t5");
    run_cmd(4'hA, 3, 0, 3, 1, "t6");
    check("t6.noqueue", 32'(busy), 32'd0);
    run_cmd(4'h0, 12, 0, 0, 0, "sat");

    // reset in the second CHECK cycle of a 10-sample run
    cmd_valid = 1'b1; cmd_value = 4'h5; cmd_len = 16'd10;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0; #1;
    model_clear();
    check("t4.load", 32'(load), 32'd0);
    check("t4.busy", 32'(busy), 32'd0);
    check("t4.done", 32'(done), 32'd0);
    check("t4.ready", 32'(cmd_ready), 32'd0);
    check_stats("t4");
    @(negedge clk); rst = 1'b1; #1;
    check("t4.rel", 32'(cmd_ready), 32'd1);

    for (int r = 0; r < 10; r++) begin
      v    = $urandom_range(0, 15);
      len  = $urandom_range(0, 15);
      mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      set_noise($urandom_range(0, 2));
      ab   = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
      n    = (ab > 0) ? ab - 1 : len;
      cl   = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
      run_cmd(4'(v), len, ab, cl, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
